// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder self-test controller.
package adder_bist_pkg;

  localparam int unsigned ERR_W   = 16;
  localparam int unsigned IDX_W   = 16;
  localparam int unsigned NUM_DIR = 8;

  // x^32+x^22+x^2+x+1, right-shifting Galois form
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE,
    DIRECTED,
    RANDOM,
    DRAIN,
    DONE
  } state_e;

  localparam logic [31:0] DIR_A [NUM_DIR] = '{
    32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFC, 32'h0000_000A,
    32'hFFFF_FFF6, 32'h0000_00A5, 32'hFFFF_FE0C, 32'hFFFF_FC19
  };
  localparam logic [31:0] DIR_B [NUM_DIR] = '{
    32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_000A,
    32'hFFFF_FFEC, 32'h0000_03E8, 32'h0000_07D0, 32'h0000_03E7
  };

endpackage

// File: rtl/adder_bist_lfsr.sv
// Galois LFSR exposing two successive words per cycle; advance steps the state twice.
module adder_bist_lfsr
  import adder_bist_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'hACE1_5EED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] word_a_c,
  output logic [WIDTH-1:0] word_b_c
);

  logic [WIDTH-1:0] state_q, state_d;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
    step = (s >> 1) ^ (s[0] ? WIDTH'(LFSR_POLY) : '0);
  endfunction

  assign word_a_c = state_q;
  assign word_b_c = step(state_q);

  always_comb begin
    state_d = state_q;
    if (load)         state_d = seed;
    else if (advance) state_d = step(word_b_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/adder_bist_ctrl.sv
// Self-test driver/checker for a WIDTH-bit adder: directed corners, LFSR vectors, golden compare.
// Define ADDER_BIST_CAPTURE_EN to add fail_* ports holding the first mismatching vector.
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_RANDOM = 256,
  parameter int unsigned LAT        = 0,
  parameter logic [31:0] SEED       = 32'hACE1_5EED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  input  logic             dut_overflow,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef ADDER_BIST_CAPTURE_EN
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH-1:0] fail_sum,
  output logic             fail_cout,
  output logic             fail_ovf,
  output logic [IDX_W-1:0] fail_idx,
`endif
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned LAST_IDX = NUM_DIR + NUM_RANDOM - 1;
  localparam int unsigned DRN_W    = $clog2(LAT + 2);
  localparam int unsigned W1       = WIDTH + 1;

  typedef struct packed {
    logic             vld;
`ifdef ADDER_BIST_CAPTURE_EN
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`endif
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  exp_t             pipe_q [LAT+1];
  exp_t             pipe_d [LAT+1];
  logic             cmp_err_q, cmp_err_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             issue_c, lfsr_load_c, lfsr_adv_c, start_ok_c, mismatch_c;
  logic [2:0]       dir_nxt_c;
  logic [WIDTH-1:0] lfsr_a_c, lfsr_b_c;
  exp_t             cmp_c;

  function automatic exp_t golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin);
    logic [WIDTH:0] full;
    full        = {1'b0, a} + {1'b0, b} + W1'(cin);
    golden      = '0;
    golden.vld  = 1'b1;
    golden.sum  = full[WIDTH-1:0];
    golden.cout = full[WIDTH];
    golden.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
  endfunction

  adder_bist_lfsr #(.WIDTH(WIDTH), .SEED(WIDTH'(SEED))) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load_c),
    .advance  (lfsr_adv_c),
    .seed     (WIDTH'(SEED)),
    .word_a_c (lfsr_a_c),
    .word_b_c (lfsr_b_c)
  );

  assign start_ok_c = start && ((state_q == IDLE) || (state_q == DONE));
  assign dir_nxt_c  = idx_q[2:0] + 3'd1;
  assign cmp_c      = pipe_q[LAT];
  // Identity compare so X/Z from the adder under test counts as a mismatch.
  assign mismatch_c = cmp_c.vld &&
                      ({dut_cout, dut_overflow, dut_sum} !== {cmp_c.cout, cmp_c.ovf, cmp_c.sum});

  // Sequencing, vector issue, golden expectation and error accounting.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    idx_d       = idx_q;
    drain_d     = drain_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    issue_c     = 1'b0;
    lfsr_load_c = 1'b0;
    lfsr_adv_c  = 1'b0;
    cmp_err_d   = mismatch_c;
    err_d       = err_q;
    if (cmp_err_q && (err_q != '1)) err_d = err_q + ERR_W'(1);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = DIRECTED;
          a_d         = WIDTH'(DIR_A[0]);
          b_d         = WIDTH'(DIR_B[0]);
          cin_d       = 1'b0;
          idx_d       = '0;
          issue_c     = 1'b1;
          lfsr_load_c = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_d       = '0;
          cmp_err_d   = 1'b0;
        end
      end
      DIRECTED: begin
        idx_d   = idx_q + IDX_W'(1);
        issue_c = 1'b1;
        if (idx_q == IDX_W'(NUM_DIR - 1)) begin
          state_d    = RANDOM;
          a_d        = lfsr_a_c;
          b_d        = lfsr_b_c;
          cin_d      = lfsr_b_c[0];
          lfsr_adv_c = 1'b1;
        end else begin
          a_d   = WIDTH'(DIR_A[dir_nxt_c]);
          b_d   = WIDTH'(DIR_B[dir_nxt_c]);
          cin_d = 1'b0;
        end
      end
      RANDOM: begin
        if (idx_q == IDX_W'(LAST_IDX)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          idx_d      = idx_q + IDX_W'(1);
          issue_c    = 1'b1;
          a_d        = lfsr_a_c;
          b_d        = lfsr_b_c;
          cin_d      = lfsr_b_c[0];
          lfsr_adv_c = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRN_W'(LAT)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    pipe_d[0] = issue_c ? golden(a_d, b_d, cin_d) : '0;
`ifdef ADDER_BIST_CAPTURE_EN
    if (issue_c) begin
      pipe_d[0].idx = idx_d;
      pipe_d[0].a   = a_d;
      pipe_d[0].b   = b_d;
      pipe_d[0].cin = cin_d;
    end
`endif
    for (int k = 1; k <= int'(LAT); k++) pipe_d[k] = pipe_q[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      idx_q     <= '0;
      drain_q   <= '0;
      cmp_err_q <= 1'b0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      for (int k = 0; k <= int'(LAT); k++) pipe_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      idx_q     <= idx_d;
      drain_q   <= drain_d;
      cmp_err_q <= cmp_err_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      for (int k = 0; k <= int'(LAT); k++) pipe_q[k] <= pipe_d[k];
    end
  end

  assign dut_a     = a_q;
  assign dut_b     = b_q;
  assign dut_cin   = cin_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

`ifdef ADDER_BIST_CAPTURE_EN
  logic             cap_q, cap_d;
  logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d, fsum_q, fsum_d;
  logic             fcin_q, fcin_d, fcout_q, fcout_d, fovf_q, fovf_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;

  // First mismatch wins; a new run clears the record.
  always_comb begin
    cap_d   = cap_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fcin_d  = fcin_q;
    fsum_d  = fsum_q;
    fcout_d = fcout_q;
    fovf_d  = fovf_q;
    fidx_d  = fidx_q;
    if (start_ok_c) begin
      cap_d   = 1'b0;
      fa_d    = '0;
      fb_d    = '0;
      fcin_d  = 1'b0;
      fsum_d  = '0;
      fcout_d = 1'b0;
      fovf_d  = 1'b0;
      fidx_d  = '0;
    end else if (mismatch_c && !cap_q) begin
      cap_d   = 1'b1;
      fa_d    = cmp_c.a;
      fb_d    = cmp_c.b;
      fcin_d  = cmp_c.cin;
      fsum_d  = dut_sum;
      fcout_d = dut_cout;
      fovf_d  = dut_overflow;
      fidx_d  = cmp_c.idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q   <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      fcin_q  <= 1'b0;
      fsum_q  <= '0;
      fcout_q <= 1'b0;
      fovf_q  <= 1'b0;
      fidx_q  <= '0;
    end else begin
      cap_q   <= cap_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fcin_q  <= fcin_d;
      fsum_q  <= fsum_d;
      fcout_q <= fcout_d;
      fovf_q  <= fovf_d;
      fidx_q  <= fidx_d;
    end
  end

  assign fail_a    = fa_q;
  assign fail_b    = fb_q;
  assign fail_cin  = fcin_q;
  assign fail_sum  = fsum_q;
  assign fail_cout = fcout_q;
  assign fail_ovf  = fovf_q;
  assign fail_idx  = fidx_q;
`endif

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Scoreboard bench: stimulus pushes expected vectors/results, negedge monitors pop and compare.
module tb_adder_bist_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned NR = 16;
  localparam logic [31:0] TB_SEED = 32'hACE1_5EED;

  typedef struct { logic [31:0] a; logic [31:0] b; logic cin; } vec_t;
  typedef struct {
    int          err;
    logic        pass;
    int          cycles;
    logic [15:0] idx;
    logic [31:0] fa;
    logic [31:0] fsum;
    logic        fcout;
    logic        fovf;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start0, start2;
  int   fault_mode;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] a0, b0, sum0, a2, b2, sum2;
  logic         cin0, cout0, ovf0, busy0, done0, pass0;
  logic         cin2, cout2, ovf2, busy2, done2, pass2;
  logic [15:0]  err0, err2;
`ifdef ADDER_BIST_CAPTURE_EN
  logic [W-1:0] fa0, fb0, fsum0, fa2, fb2, fsum2;
  logic         fcin0, fcout0, fovf0, fcin2, fcout2, fovf2;
  logic [15:0]  fidx0, fidx2;
`endif

  vec_t vec_q[$];
  res_t res_q0[$];
  res_t res_q2[$];

  logic [31:0] dir_a [8];
  logic [31:0] dir_b [8];

  // Adder under test: golden, cout inverted (mode 1), overflow tied low (mode 2).
  logic [W:0] full0;
  always_comb begin
    full0 = {1'b0, a0} + {1'b0, b0} + {32'b0, cin0};
    sum0  = full0[W-1:0];
    cout0 = full0[W] ^ (fault_mode == 1);
    ovf0  = (fault_mode == 2) ? 1'b0 : ((a0[31] == b0[31]) && (full0[31] != a0[31]));
  end

  // Two-stage registered golden adder for the LAT=2 instance.
  logic [W:0]   full2;
  logic [W+1:0] p2a, p2b;
  always_comb full2 = {1'b0, a2} + {1'b0, b2} + {32'b0, cin2};
  always_ff @(posedge clk) begin
    p2a <= {(a2[31] == b2[31]) && (full2[31] != a2[31]), full2};
    p2b <= p2a;
  end
  assign sum2 = p2b[W-1:0];
  assign cout2 = p2b[W];
  assign ovf2 = p2b[W+1];

  adder_bist_ctrl #(.WIDTH(W), .NUM_RANDOM(NR), .LAT(0), .SEED(TB_SEED)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .dut_a(a0), .dut_b(b0), .dut_cin(cin0),
    .dut_sum(sum0), .dut_cout(cout0), .dut_overflow(ovf0),
    .busy(busy0), .done(done0), .pass(pass0),
`ifdef ADDER_BIST_CAPTURE_EN
    .fail_a(fa0), .fail_b(fb0), .fail_cin(fcin0), .fail_sum(fsum0),
    .fail_cout(fcout0), .fail_ovf(fovf0), .fail_idx(fidx0),
`endif
    .err_count(err0)
  );

  adder_bist_ctrl #(.WIDTH(W), .NUM_RANDOM(NR), .LAT(2), .SEED(TB_SEED)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .dut_a(a2), .dut_b(b2), .dut_cin(cin2),
    .dut_sum(sum2), .dut_cout(cout2), .dut_overflow(ovf2),
    .busy(busy2), .done(done2), .pass(pass2),
`ifdef ADDER_BIST_CAPTURE_EN
    .fail_a(fa2), .fail_b(fb2), .fail_cin(fcin2), .fail_sum(fsum2),
    .fail_cout(fcout2), .fail_ovf(fovf2), .fail_idx(fidx2),
`endif
    .err_count(err2)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ ((32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1);
    return n;
  endfunction

  // Expected issue sequence and final result for one LAT=0 run in the given fault mode.
  task automatic push_run0(input int mode);
    logic [31:0] s, a, b;
    logic        c, ov;
    logic [32:0] f;
    int          e;
    vec_t        v;
    res_t        r;
    s = TB_SEED;
    e = 0;
    for (int i = 0; i < 8 + int'(NR); i++) begin
      if (i < 8) begin
        a = dir_a[i]; b = dir_b[i]; c = 1'b0;
      end else begin
        a = s; s = lstep(s); b = s; s = lstep(s); c = b[0];
      end
      v.a = a; v.b = b; v.cin = c;
      vec_q.push_back(v);
      f  = {1'b0, a} + {1'b0, b} + {32'b0, c};
      ov = (a[31] == b[31]) && (f[31] != a[31]);
      if (mode == 1 || (mode == 2 && ov)) e++;
    end
    r.err    = e;
    r.pass   = (e == 0);
    r.cycles = 8 + int'(NR) + 0 + 1;
    r.idx    = 16'h0;
    r.fa     = (mode != 0) ? 32'h7FFF_FFFF : 32'h0;
    r.fsum   = (mode != 0) ? 32'h8000_0000 : 32'h0;
    r.fcout  = (mode == 1);
    r.fovf   = (mode == 1);
    res_q0.push_back(r);
  endtask

  // Monitor for the LAT=0 instance: issued vectors while busy, result when done rises.
  int   bcnt0 = 0, vcnt0 = 0, bcnt2 = 0;
  logic done0_prev = 1'b0, done2_prev = 1'b0;
  always @(negedge clk) begin
    vec_t v;
    res_t r;
    if (rst) begin
      bcnt0 = 0; vcnt0 = 0;
    end else begin
      if (busy0) begin
        if (vcnt0 < 8 + int'(NR)) begin
          if (vec_q.size() == 0) chk("vec_underflow", 64'd1, 64'd0);
          else begin
            v = vec_q.pop_front();
            chk("vec_a", 64'(a0), 64'(v.a));
            chk("vec_b_cin", 64'({b0, cin0}), 64'({v.b, v.cin}));
          end
          vcnt0++;
        end
        bcnt0++;
      end
      if (done0 && !done0_prev) begin
        if (res_q0.size() == 0) chk("res0_underflow", 64'd1, 64'd0);
        else begin
          r = res_q0.pop_front();
          chk("err_count", 64'(err0), 64'(r.err));
          chk("pass", 64'(pass0), 64'(r.pass));
          chk("busy_cycles", 64'(bcnt0), 64'(r.cycles));
`ifdef ADDER_BIST_CAPTURE_EN
          chk("fail_idx", 64'(fidx0), 64'(r.idx));
          chk("fail_a", 64'(fa0), 64'(r.fa));
          chk("fail_sum", 64'(fsum0), 64'(r.fsum));
          chk("fail_cout_ovf", 64'({fcout0, fovf0}), 64'({r.fcout, r.fovf}));
`endif
        end
        bcnt0 = 0; vcnt0 = 0;
      end
    end
    done0_prev = done0;
  end

  // Monitor for the LAT=2 instance.
  always @(negedge clk) begin
    res_t r;
    if (rst) bcnt2 = 0;
    else begin
      if (busy2) bcnt2++;
      if (done2 && !done2_prev) begin
        if (res_q2.size() == 0) chk("res2_underflow", 64'd1, 64'd0);
        else begin
          r = res_q2.pop_front();
          chk("lat2_err_count", 64'(err2), 64'(r.err));
          chk("lat2_pass", 64'(pass2), 64'(r.pass));
          chk("lat2_busy_cycles", 64'(bcnt2), 64'(r.cycles));
        end
        bcnt2 = 0;
      end
    end
    done2_prev = done2;
  end

  task automatic pulse(input logic s0, input logic s2);
    @(negedge clk);
    start0 = s0; start2 = s2;
    @(negedge clk);
    start0 = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_done(input int which);
    int n;
    n = 0;
    while (((which == 0) ? done0 : done2) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done%0d_timeout", which), 64'(n >= 200), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy_done_pass"}, 64'({busy0, done0, pass0}), 64'd0);
    chk({tag, "_err_count"}, 64'(err0), 64'd0);
    chk({tag, "_dut_ops"}, 64'({a0[31:0], b0[30:0], cin0}), 64'd0);
  endtask

  initial begin
    res_t r2;
    dir_a = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFC, 32'h0000_000A,
              32'hFFFF_FFF6, 32'h0000_00A5, 32'hFFFF_FE0C, 32'hFFFF_FC19};
    dir_b = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_000A,
              32'hFFFF_FFEC, 32'h0000_03E8, 32'h0000_07D0, 32'h0000_03E7};
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; fault_mode = 0;
    repeat (2) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // Golden adder on both instances; LAT=2 finishes two cycles later.
    push_run0(0);
    r2 = '{err: 0, pass: 1'b1, cycles: 8 + int'(NR) + 2 + 1, idx: '0, fa: '0, fsum: '0,
           fcout: 1'b0, fovf: 1'b0};
    res_q2.push_back(r2);
    pulse(1'b1, 1'b1);
    wait_done(0);
    wait_done(2);

    // Carry-out inverted: every vector mismatches.
    fault_mode = 1;
    push_run0(1);
    pulse(1'b1, 1'b0);
    wait_done(0);

    // Overflow tied low: mismatches only where the golden model overflows.
    fault_mode = 2;
    push_run0(2);
    pulse(1'b1, 1'b0);
    wait_done(0);

    // Starts while busy are ignored; timing and result match a clean run.
    fault_mode = 0;
    push_run0(0);
    pulse(1'b1, 1'b0);
    repeat (8) @(negedge clk);
    pulse(1'b1, 1'b0);
    repeat (12) @(negedge clk);
    pulse(1'b1, 1'b0);
    wait_done(0);

    // Reset in the middle of the random phase clears everything at once.
    push_run0(0);
    pulse(1'b1, 1'b0);
    repeat (12) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_cleared("midrun_rst");
    vec_q.delete();
    res_q0.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_run0(0);
    pulse(1'b1, 1'b0);
    wait_done(0);

    chk("vec_q_left", 64'(vec_q.size()), 64'd0);
    chk("res_q_left", 64'(res_q0.size() + res_q2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
